// File: rtl/div_pkg.sv
// Shared types and default sizing for the divide/sqrt sequencer and its rounding units.
package div_pkg;

    localparam int DEF_WIDTH = 28;
    localparam int DEF_ULP   = 4;

    typedef enum logic [2:0] {
        IDLE = 3'd0,
        ITER = 3'd1,
        REM  = 3'd2,
        RND  = 3'd3,
        DONE = 3'd4
    } state_t;

    typedef enum logic {
        RM_NE = 1'b0,
        RM_Z  = 1'b1
    } rmode_t;

endpackage

// File: rtl/round_ne.sv
// Round-to-nearest-even unit: bumps the raw quotient by half a ULP when the
// guard bit is set and the true remainder is strictly positive.
module round_ne
    import div_pkg::*;
#(
    parameter int WIDTH = DEF_WIDTH,
    parameter int ULP   = DEF_ULP
) (
    input  logic [WIDTH-1:0] q,
    input  logic             pos,
    output logic [WIDTH-1:0] y
);

    localparam logic [WIDTH-1:0] ONE  = {{(WIDTH-1){1'b0}}, 1'b1};
    localparam logic [WIDTH-1:0] HALF = ONE << (ULP - 1);
    localparam logic [WIDTH-1:0] MASK = ~((ONE << ULP) - ONE);

    // Round up by half a ULP or truncate the guard bits.
    always_comb begin
        y = q & MASK;
        if (q[ULP-1] & pos) begin
            y = q + HALF;
        end else begin
            y = q & MASK;
        end
    end

endmodule

// File: rtl/round_z.sv
// Round-toward-zero unit: steps the raw quotient down by half a ULP when the
// guard bit is clear and the true remainder is negative.
module round_z
    import div_pkg::*;
#(
    parameter int WIDTH = DEF_WIDTH,
    parameter int ULP   = DEF_ULP
) (
    input  logic [WIDTH-1:0] q,
    input  logic             neg,
    output logic [WIDTH-1:0] y
);

    localparam logic [WIDTH-1:0] ONE  = {{(WIDTH-1){1'b0}}, 1'b1};
    localparam logic [WIDTH-1:0] HALF = ONE << (ULP - 1);
    localparam logic [WIDTH-1:0] MASK = ~((ONE << ULP) - ONE);

    // Correct an overestimated quotient downward or truncate the guard bits.
    always_comb begin
        y = q & MASK;
        if (~q[ULP-1] & neg) begin
            y = q - HALF;
        end else begin
            y = q & MASK;
        end
    end

endmodule

// File: rtl/div_round_seq.sv
// Sequencer for the iterative divide/sqrt datapath: load, iterate, remainder,
// round with the mode latched at issue, then hold the result for the consumer.
module div_round_seq
    import div_pkg::*;
#(
    parameter int WIDTH = DEF_WIDTH,
    parameter int ULP   = DEF_ULP,
    parameter int ITERS = 4,
    parameter int CNT_W = $clog2(ITERS + 1)
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             start_valid,
    output logic             start_ready,
    input  logic             rm,
    output logic             ld_op,
    output logic             iter_en,
    output logic [CNT_W-1:0] iter_cnt,
    output logic             rem_en,
    input  logic [WIDTH-1:0] q_in,
    input  logic             rem_sign,
    input  logic             rem_zero,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] y
);

    localparam logic [CNT_W-1:0] LAST = CNT_W'(ITERS - 1);
    localparam logic [CNT_W-1:0] CNT1 = CNT_W'(1);

    state_t           state;
    state_t           state_nxt;
    rmode_t           rm_lat;
    logic [CNT_W-1:0] cnt;
    logic [WIDTH-1:0] y_ne;
    logic [WIDTH-1:0] y_z;
    logic [WIDTH-1:0] y_rnd;
    logic             pos;
    logic             neg;

    assign pos      = ~rem_sign & ~rem_zero;
    assign neg      = rem_sign;
    assign iter_cnt = cnt;

    round_ne #(.WIDTH(WIDTH), .ULP(ULP)) u_round_ne (
        .q   (q_in),
        .pos (pos),
        .y   (y_ne)
    );

    round_z #(.WIDTH(WIDTH), .ULP(ULP)) u_round_z (
        .q   (q_in),
        .neg (neg),
        .y   (y_z)
    );

    assign y_rnd = (rm_lat == RM_Z) ? y_z : y_ne;

    // Next-state and handshake/enable decode; accept in DONE chains straight into ITER.
    always_comb begin
        state_nxt   = state;
        start_ready = 1'b0;
        ld_op       = 1'b0;
        iter_en     = 1'b0;
        rem_en      = 1'b0;
        out_valid   = 1'b0;
        case (state)
            IDLE: begin
                start_ready = 1'b1;
                if (start_valid) begin
                    ld_op     = 1'b1;
                    state_nxt = ITER;
                end else begin
                    state_nxt = IDLE;
                end
            end
            ITER: begin
                iter_en = 1'b1;
                if (cnt == LAST) begin
                    state_nxt = REM;
                end else begin
                    state_nxt = ITER;
                end
            end
            REM: begin
                rem_en    = 1'b1;
                state_nxt = RND;
            end
            RND: begin
                state_nxt = DONE;
            end
            DONE: begin
                out_valid   = 1'b1;
                start_ready = out_ready;
                if (out_ready & start_valid) begin
                    ld_op     = 1'b1;
                    state_nxt = ITER;
                end else if (out_ready) begin
                    state_nxt = IDLE;
                end else begin
                    state_nxt = DONE;
                end
            end
            default: begin
                state_nxt = IDLE;
            end
        endcase
    end

    // State, iteration counter, latched rounding mode and result register.
    always_ff @(posedge clk) begin
        if (reset) begin
            state  <= IDLE;
            cnt    <= {CNT_W{1'b0}};
            rm_lat <= RM_NE;
            y      <= {WIDTH{1'b0}};
        end else begin
            state <= state_nxt;
            if (state == ITER) begin
                cnt <= (cnt == LAST) ? {CNT_W{1'b0}} : cnt + CNT1;
            end else begin
                cnt <= cnt;
            end
            if (ld_op) begin
                rm_lat <= rmode_t'(rm);
            end else begin
                rm_lat <= rm_lat;
            end
            if (state == RND) begin
                y <= y_rnd;
            end else begin
                y <= y;
            end
        end
    end

endmodule
